// File: rtl/timer_ctrl_if.sv
// Configuration port of timer_ctrl: a valid/ready offer of limit, burst count and mode.
interface timer_ctrl_if #(
  parameter int unsigned SIZE  = 26,
  parameter int unsigned REP_W = 8
);
  logic             valid;
  logic             ready;
  logic [SIZE-1:0]  limit;
  logic [REP_W-1:0] reps;
  logic             mode;

  modport master (output valid, limit, reps, mode, input ready);
  modport slave  (input valid, limit, reps, mode, output ready);
endinterface

// File: rtl/timer_ctrl.sv
// Programmable tick/divider: periodic or N-tick burst runs, reconfigured between runs
// through a valid/ready port.
module timer_ctrl #(
  parameter int unsigned     SIZE          = 26,
  parameter logic [SIZE-1:0] DEFAULT_LIMIT = SIZE'(50000000),
  parameter int unsigned     REP_W         = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  timer_ctrl_if.slave      cfg,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             clk_out,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] reps_left
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [SIZE-1:0]  count, count_n;
  logic [SIZE-1:0]  limit_r, limit_n;
  logic [REP_W-1:0] reps_r, reps_n, reps_left_n;
  logic             mode_r, mode_n;
  logic             clk_out_n, busy_n, done_n;
  logic             accept;

  assign cfg.ready = (state == IDLE) && !rst;
  assign accept    = cfg.valid && cfg.ready;
  assign tick      = (state == RUN) && (count == limit_r);

  // Next-state and next-output decode; an accepted config is visible to a same-edge start.
  always_comb begin
    state_n     = state;
    count_n     = count;
    clk_out_n   = clk_out;
    reps_left_n = reps_left;
    limit_n     = limit_r;
    reps_n      = reps_r;
    mode_n      = mode_r;

    if (accept) begin
      limit_n = cfg.limit;
      reps_n  = cfg.reps;
      mode_n  = cfg.mode;
    end

    unique case (state)
      IDLE: begin
        count_n     = '0;
        clk_out_n   = 1'b0;
        reps_left_n = '0;
        if (start && !stop) begin
          if (mode_n && (reps_n == '0)) begin
            state_n = DONE;
          end else begin
            state_n     = RUN;
            reps_left_n = reps_n;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_n     = IDLE;
          count_n     = '0;
          clk_out_n   = 1'b0;
          reps_left_n = '0;
        end else if (tick) begin
          count_n   = '0;
          clk_out_n = ~clk_out;
          if (mode_r) begin
            if (reps_left == REP_W'(1)) begin
              state_n     = DONE;
              reps_left_n = '0;
            end else begin
              reps_left_n = reps_left - REP_W'(1);
            end
          end
        end else begin
          count_n = count + SIZE'(1);
        end
      end
      DONE: begin
        state_n   = IDLE;
        count_n   = '0;
        clk_out_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      clk_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reps_left <= '0;
      limit_r   <= DEFAULT_LIMIT;
      reps_r    <= REP_W'(1);
      mode_r    <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      clk_out   <= clk_out_n;
      busy      <= busy_n;
      done      <= done_n;
      reps_left <= reps_left_n;
      limit_r   <= limit_n;
      reps_r    <= reps_n;
      mode_r    <= mode_n;
    end
  end

endmodule
